// File: rtl/pc_pkg.sv
// Shared constants and the operation encoding for the program counter.
package pc_pkg;

  localparam int unsigned PC_WIDTH       = 16;
  localparam int unsigned PC_RESET_VALUE = 0;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_INC,
    OP_LOAD,
    OP_RESET
  } pc_op_t;

endpackage

// File: rtl/pc_incrementer.sv
// Combinational WIDTH-bit +1; carry-out is set only when the input is all-ones.
module pc_incrementer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_value,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  logic [WIDTH:0] w_full;

  assign w_full  = {1'b0, i_value} + (WIDTH + 1)'(1);
  assign o_sum   = w_full[WIDTH-1:0];
  assign o_carry = w_full[WIDTH];

endmodule

// File: rtl/program_counter.sv
// Registered program counter: priority reset > load > increment > hold.
// Define PC_WRAP_FLAG_EN to add the registered `wrap` output.
module program_counter
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = PC_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
`ifdef PC_WRAP_FLAG_EN
  output logic             wrap,
`endif
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] w_out_next;
  logic [WIDTH-1:0] w_inc_sum;
  logic             w_inc_carry;
  pc_op_t           w_op;

  pc_incrementer #(
    .WIDTH (WIDTH)
  ) u_incrementer (
    .i_value (r_out),
    .o_sum   (w_inc_sum),
    .o_carry (w_inc_carry)
  );

  // Reset appears in the decode for completeness; the register also clears asynchronously.
  always_comb begin
    w_op = OP_HOLD;
    if (reset)     w_op = OP_RESET;
    else if (load) w_op = OP_LOAD;
    else if (inc)  w_op = OP_INC;
  end

  always_comb begin
    w_out_next = r_out;
    case (w_op)
      OP_RESET: w_out_next = WIDTH'(PC_RESET_VALUE);
      OP_LOAD:  w_out_next = in;
      OP_INC:   w_out_next = w_inc_sum;
      default:  w_out_next = r_out;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_out <= WIDTH'(PC_RESET_VALUE);
    else       r_out <= w_out_next;
  end

  assign out = r_out;

`ifdef PC_WRAP_FLAG_EN
  logic r_wrap;

  // Only an increment out of all-ones raises the flag; a load of zero does not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_wrap <= 1'b0;
    else       r_wrap <= (w_op == OP_INC) && w_inc_carry;
  end

  assign wrap = r_wrap;
`else
  logic w_unused_carry;
  assign w_unused_carry = w_inc_carry;
`endif

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed cases followed by random load/inc/reset traffic.
module tb_program_counter;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in;
  logic         load;
  logic         inc;
  logic [W-1:0] out;
`ifdef PC_WRAP_FLAG_EN
  logic         wrap;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: integer address modulo 2^W plus the expected wrap flag.
  int m_pc   = 0;
  int m_wrap = 0;

  always #5 clk = ~clk;

  program_counter #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .load  (load),
    .inc   (inc),
`ifdef PC_WRAP_FLAG_EN
    .wrap  (wrap),
`endif
    .out   (out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check(tag, 32'(out), 32'(m_pc));
`ifdef PC_WRAP_FLAG_EN
    check({tag, "_wrap"}, 32'(wrap), 32'(m_wrap));
`endif
  endtask

  // One clock edge with the given controls, then compare against the model.
  task automatic step(input bit l, input bit i, input int d, input string tag);
    @(negedge clk);
    load = l;
    inc  = i;
    in   = d[W-1:0];
    @(posedge clk);
    if (l) begin
      m_pc   = d % (1 << W);
      m_wrap = 0;
    end else if (i) begin
      m_wrap = (m_pc == (1 << W) - 1) ? 1 : 0;
      m_pc   = (m_pc + 1) % (1 << W);
    end else begin
      m_wrap = 0;
    end
    #1 check_state(tag);
  endtask

  // Raise reset between edges with load/inc active; out must clear before any edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    load  = 1'b1;
    inc   = 1'b1;
    in    = 16'h5A5A;
    reset = 1'b1;
    #1;
    m_pc   = 0;
    m_wrap = 0;
    check_state({tag, "_async"});
    @(posedge clk);
    #1 check_state({tag, "_held"});
    @(negedge clk);
    reset = 1'b0;
    load  = 1'b0;
    inc   = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    in    = '0;
    load  = 1'b0;
    inc   = 1'b0;
    @(posedge clk);
    #1 check_state("reset_state");
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 0, "inc_from_0");
    step(1'b1, 1'b0, 16'h00FF, "load_00ff");
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 0, "inc_carry");
    step(1'b1, 1'b0, 16'hFFFF, "load_ffff");
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 16'hFFFF, "wrap_inc");
    step(1'b1, 1'b1, 16'h1234, "load_wins");
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, int'($urandom_range(0, 65535)), "hold");
    step(1'b1, 1'b0, 0, "load_zero");
    step(1'b0, 1'b1, 0, "inc_after_load0");
    step(1'b0, 1'b1, 0, "inc_to_2");
    async_reset("reset_mid");
    step(1'b0, 1'b1, 0, "inc_after_reset");

    for (int n = 0; n < 400; n++) begin
      int r;
      int d;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        async_reset("rand_reset");
      end else begin
        d = (r < 8) ? int'($urandom_range(65533, 65535)) : int'($urandom_range(0, 65535));
        step(r < 15, $urandom_range(0, 3) != 0, d, "random");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
